// File: rtl/aes_shiftrows_colser.sv
`default_nettype none
// ============================================================================
//  Module   : aes_shiftrows_colser
//  Brief    : AES-128 ShiftRows stage that buffers one post-SubBytes state and
//             serialises the shifted result as four 32-bit columns for the
//             downstream MixColumns column unit. Carries the last-round flag.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_shiftrows_colser #(
    parameter int NCOL = 4      // columns per state; only 4 (AES-128) is supported
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_state,
    input  logic          in_last,
    output logic          col_valid,
    input  logic          col_ready,
    output logic [31:0]   col_data,
    output logic [1:0]    col_idx,
    output logic          col_lastrnd,
    output logic          col_eos
);

    // Index of the final column of a state; its accept ends the state.
    localparam logic [1:0] c_LAST_IDX = 2'(NCOL - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t         r_state_q, w_state_d;
    logic [127:0]   r_buf_q,   w_buf_d;
    logic           r_last_q,  w_last_d;
    logic [1:0]     r_idx_q,   w_idx_d;

    logic           w_in_acc;
    logic           w_col_acc;
    logic           w_idx_last;
    logic [31:0]    w_cols [NCOL];

    // ShiftRows on the stored state: output column c, row r takes the byte
    // from input column (c + r) mod 4 of the same row. Byte k of the state
    // sits at bits [127-8k -: 8] with row = k % 4, column = k / 4.
    genvar gc, gr;
    generate
        for (gc = 0; gc < NCOL; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign w_cols[gc][31-8*gr -: 8] =
                    r_buf_q[127-8*(4*((gc+gr)%NCOL)+gr) -: 8];
            end
        end
    endgenerate

    assign w_idx_last = (r_idx_q == c_LAST_IDX);

    // Ready is combinational on col_ready so a new state can be taken in the
    // same cycle the final column leaves, giving 4 cycles per block.
    assign in_ready  = (r_state_q == S_IDLE) |
                       ((r_state_q == S_EMIT) & w_idx_last & col_ready);
    assign w_in_acc  = in_valid & in_ready;
    assign w_col_acc = col_valid & col_ready;

    assign col_valid   = (r_state_q == S_EMIT);
    assign col_idx     = r_idx_q;
    assign col_lastrnd = r_last_q;
    assign col_eos     = col_valid & w_idx_last;
    assign col_data    = w_cols[r_idx_q];

    // Next-state logic: load the buffer on input accept, step the column
    // index on column accept, reload without a bubble on the final column.
    always_comb begin
        w_state_d = r_state_q;
        w_buf_d   = r_buf_q;
        w_last_d  = r_last_q;
        w_idx_d   = r_idx_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_in_acc) begin
                    w_buf_d   = in_state;
                    w_last_d  = in_last;
                    w_idx_d   = 2'd0;
                    w_state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_col_acc) begin
                    if (!w_idx_last) begin
                        w_idx_d = r_idx_q + 2'd1;
                    end else begin
                        w_idx_d = 2'd0;
                        if (w_in_acc) begin
                            w_buf_d  = in_state;
                            w_last_d = in_last;
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_idx_d   = 2'd0;
            end
        endcase
    end

    // State registers; reset clears the buffer so idle output is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_buf_q   <= '0;
            r_last_q  <= 1'b0;
            r_idx_q   <= 2'd0;
        end else begin
            r_state_q <= w_state_d;
            r_buf_q   <= w_buf_d;
            r_last_q  <= w_last_d;
            r_idx_q   <= w_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_shiftrows_colser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_shiftrows_colser
//  Brief    : Self-checking bench for aes_shiftrows_colser: directed FIPS-197
//             vectors, stalls, back-to-back and reset scenarios, plus a
//             randomized run against a queue-based column model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_shiftrows_colser;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_state;
    logic          in_last;
    logic          col_valid;
    logic          col_ready;
    logic [31:0]   col_data;
    logic [1:0]    col_idx;
    logic          col_lastrnd;
    logic          col_eos;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] c_FIPS = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] c_IDNT = 128'h000102030405060708090a0b0c0d0e0f;

    aes_shiftrows_colser #(.NCOL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_last    (in_last),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_data   (col_data),
        .col_idx    (col_idx),
        .col_lastrnd(col_lastrnd),
        .col_eos    (col_eos)
    );

    always #5 clk = ~clk;

    // {valid, idx, eos, lastrnd, data, in_ready}
    logic [37:0] w_obs;
    assign w_obs = {col_valid, col_idx, col_eos, col_lastrnd, col_data, in_ready};
    // idle view: {valid, idx, eos, in_ready}
    logic [4:0] w_idle;
    assign w_idle = {col_valid, col_idx, col_eos, in_ready};

    // Reference ShiftRows: build the 4x4 byte matrix, rotate row r left by r.
    function automatic logic [31:0] ref_col(input logic [127:0] s, input int c);
        logic [7:0] m [4][4];
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127 - 8*k -: 8];
        return {m[0][c], m[1][(c+1)%4], m[2][(c+2)%4], m[3][(c+3)%4]};
    endfunction

    function automatic logic [37:0] ev(input logic v, input logic [1:0] i,
                                       input logic e, input logic l,
                                       input logic [31:0] d, input logic r);
        return {v, i, e, l, d, r};
    endfunction

    function automatic logic [127:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_last = 1'b0; col_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (w_obs !== ev(0, 0, 0, 0, 32'h0, 1)) begin
            errors++; $display("FAIL reset_state got %h exp %h", w_obs, ev(0, 0, 0, 0, 32'h0, 1));
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (w_obs !== ev(0, 0, 0, 0, 32'h0, 1)) begin
            errors++; $display("FAIL reset_release got %h exp %h", w_obs, ev(0, 0, 0, 0, 32'h0, 1));
        end
    endtask

    // Load one state, drain it with col_ready=1, check all four columns.
    task automatic run_state(input string nm, input logic [127:0] s, input logic l);
        logic [37:0] e;
        tick();
        in_valid = 1'b1; in_state = s; in_last = l; col_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w_idle !== 5'b0_00_0_1) begin
            errors++; $display("FAIL %s_idle_ready got %b exp 00001", nm, w_idle);
        end
        tick();
        in_valid = 1'b0; in_state = rnd_state();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = ev(1, 2'(i), i == 3, l, ref_col(s, i), i == 3);
            checks++;
            if (w_obs !== e) begin
                errors++; $display("FAIL %s_col%0d got %h exp %h", nm, i, w_obs, e);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (w_idle !== 5'b0_00_0_1) begin
            errors++; $display("FAIL %s_end_idle got %b exp 00001", nm, w_idle);
        end
    endtask

    task automatic test_fips();
        // Explicit FIPS-197 round-1 column values.
        checks++;
        if (ref_col(c_FIPS, 1) !== 32'he0b452ae) begin
            errors++; $display("FAIL fips_model got %h exp e0b452ae", ref_col(c_FIPS, 1));
        end
        run_state("fips", c_FIPS, 1'b0);
    endtask

    task automatic test_identity();
        run_state("ident", c_IDNT, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [37:0] e;
        tick();
        in_valid = 1'b1; in_state = c_FIPS; in_last = 1'b0; col_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (w_obs !== ev(1, 0, 0, 0, 32'hd4bf5d30, 0)) begin
            errors++; $display("FAIL bp_col0 got %h exp %h", w_obs, ev(1, 0, 0, 0, 32'hd4bf5d30, 0));
        end
        tick();
        col_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== ev(1, 1, 0, 0, 32'he0b452ae, 0)) begin
                errors++; $display("FAIL bp_hold%0d got %h exp %h", i, w_obs, ev(1, 1, 0, 0, 32'he0b452ae, 0));
            end
            tick();
        end
        col_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            e = ev(1, 2'(i), i == 3, 0, ref_col(c_FIPS, i), i == 3);
            checks++;
            if (w_obs !== e) begin
                errors++; $display("FAIL bp_resume%0d got %h exp %h", i, w_obs, e);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (w_idle !== 5'b0_00_0_1) begin
            errors++; $display("FAIL bp_end_idle got %b exp 00001", w_idle);
        end
    endtask

    task automatic test_col3_stall();
        logic [127:0] b;
        logic [37:0]  e;
        b = rnd_state();
        tick();
        in_valid = 1'b1; in_state = c_IDNT; in_last = 1'b0; col_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        col_ready = 1'b0; in_valid = 1'b1; in_state = b; in_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== ev(1, 3, 1, 0, 32'h0c01060b, 0)) begin
                errors++; $display("FAIL c3_stall%0d got %h exp %h", i, w_obs, ev(1, 3, 1, 0, 32'h0c01060b, 0));
            end
            tick();
        end
        col_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w_obs !== ev(1, 3, 1, 0, 32'h0c01060b, 1)) begin
            errors++; $display("FAIL c3_release got %h exp %h", w_obs, ev(1, 3, 1, 0, 32'h0c01060b, 1));
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = ev(1, 2'(i), i == 3, 1, ref_col(b, i), i == 3);
            checks++;
            if (w_obs !== e) begin
                errors++; $display("FAIL c3_next%0d got %h exp %h", i, w_obs, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        logic [37:0]  e;
        a = rnd_state(); b = rnd_state();
        tick();
        in_valid = 1'b1; in_state = a; in_last = 1'b0; col_ready = 1'b1;
        tick();
        in_state = b; in_last = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            e = (n < 4) ? ev(1, 2'(n), n == 3, 0, ref_col(a, n), n == 3)
                        : ev(1, 2'(n - 4), n == 7, 1, ref_col(b, n - 4), n == 7);
            checks++;
            if (w_obs !== e) begin
                errors++; $display("FAIL b2b_col%0d got %h exp %h", n, w_obs, e);
            end
            tick();
            if (n == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (w_idle !== 5'b0_00_0_1) begin
            errors++; $display("FAIL b2b_end_idle got %b exp 00001", w_idle);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] g;
        logic [37:0]  e;
        g = rnd_state();
        tick();
        in_valid = 1'b1; in_state = c_FIPS; in_last = 1'b1; col_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (w_obs !== ev(0, 0, 0, 0, 32'h0, 1)) begin
            errors++; $display("FAIL rstmid_async got %h exp %h", w_obs, ev(0, 0, 0, 0, 32'h0, 1));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (w_obs !== ev(0, 0, 0, 0, 32'h0, 1)) begin
                errors++; $display("FAIL rstmid_quiet%0d got %h exp %h", i, w_obs, ev(0, 0, 0, 0, 32'h0, 1));
            end
        end
        tick();
        in_valid = 1'b1; in_state = g; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = ev(1, 2'(i), i == 3, 0, ref_col(g, i), i == 3);
            checks++;
            if (w_obs !== e) begin
                errors++; $display("FAIL rstmid_new%0d got %h exp %h", i, w_obs, e);
            end
            tick();
        end
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  i;
        logic        l;
    } col_t;

    // Random traffic on both channels against a queue of pending columns.
    task automatic test_random();
        col_t q[$];
        logic exp_rdy;
        rst = 1'b1; in_valid = 1'b0; col_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tick();
            in_valid  = ($urandom % 3) != 0;
            in_state  = rnd_state();
            in_last   = 1'($urandom % 2);
            col_ready = ($urandom % 4) != 0;
            @(negedge clk);
            exp_rdy = (q.size() == 0) || (q.size() == 1 && col_ready);
            checks++;
            if (in_ready !== exp_rdy || col_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_hs cyc %0d got rdy %b vld %b exp rdy %b vld %b",
                                   n, in_ready, col_valid, exp_rdy, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({col_data, col_idx, col_lastrnd, col_eos} !== {q[0], q[0].i == 2'd3}) begin
                    errors++; $display("FAIL rnd_col cyc %0d got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                                       n, col_data, col_idx, col_lastrnd, col_eos,
                                       q[0].d, q[0].i, q[0].l, q[0].i == 2'd3);
                end
                if (col_ready) void'(q.pop_front());
            end
            if (in_valid && exp_rdy)
                for (int c = 0; c < 4; c++) q.push_back('{ref_col(in_state, c), 2'(c), in_last});
        end
        tick();
        in_valid = 1'b0;
        col_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_identity();
        test_backpressure();
        test_col3_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_shiftrows_colser.md
Name: aes_shiftrows_colser

Overview:
- Upstream neighbour of the 32-bit MixColumns column unit in the AES-128 round datapath.
- Accepts a full 128-bit state after SubBytes and applies ShiftRows.
- Emits the result as four 32-bit columns, one per accepted beat, in the byte order the column mixer expects.
- Carries a last-round flag so downstream logic can bypass MixColumns in round 10.
- One-state-deep buffer with back-to-back acceptance, so the stream sustains 4 cycles per block.

Parameters:
- NCOL, 4, columns per state; fixed for AES-128, any other value unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  in_state/in_last are valid
- in_ready  output  1  block can accept a state this cycle
- in_state  input  128  post-SubBytes state, column-major; byte k = in_state[127-8k -: 8], row = k%4, col = k/4
- in_last  input  1  state belongs to final round (no MixColumns)
- col_valid  output  1  col_data valid
- col_ready  input  1  downstream accepts column this cycle
- col_data  output  32  shifted column {row0,row1,row2,row3}, row0 in [31:24]
- col_idx  output  2  column index 0..3 of col_data
- col_lastrnd  output  1  registered copy of in_last for the state being emitted
- col_eos  output  1  high with column 3 (end of state)

Behaviour:
- Reset (async, rst=1): col_valid=0, col_idx=0, col_lastrnd=0, col_eos=0, internal buffer cleared to 0, state=IDLE. in_ready=1 once reset deasserts.
- A handshake completes on a channel only when valid and ready are both 1 at the rising clk edge.
- ShiftRows: out(r,c) = in(r,(c+r) mod 4). col_data for column c = {out(0,c),out(1,c),out(2,c),out(3,c)}.
- ShiftRows is applied combinationally to the stored buffer. The 32-bit column is selected by col_idx. col_data is a mux of registered state.
- FSM states:
  - IDLE: col_valid=0, in_ready=1. On input accept: latch in_state and in_last, col_idx:=0, go to EMIT.
  - EMIT: col_valid=1.
    - On column accept with col_idx<3: col_idx increments.
    - On column accept with col_idx==3, no new input: go to IDLE, col_idx:=0.
    - On column accept with col_idx==3 and simultaneous input accept: reload buffer, col_idx:=0, stay in EMIT. No bubble.
- in_ready = (state==IDLE) | (state==EMIT & col_idx==3 & col_ready). This is combinational from col_ready; it is the only comb path from input to output.
- Latency: state accepted at edge N → column 0 valid in cycle N+1. With col_ready held 1, columns 0..3 are output in cycles N+1..N+4.
- Backpressure: while col_valid=1 and col_ready=0, col_data, col_idx, col_lastrnd and col_eos hold stable. col_valid never drops before acceptance.
- in_state changes while in_ready=0 are ignored; the buffer is only written on input handshake.
- col_eos = col_valid & (col_idx==3). col_lastrnd is constant across all 4 columns of a state.
- col_idx wraps 3→0 only on the accept of column 3.
- rst asserted mid-state: the partial state is discarded immediately. Outputs return to reset values asynchronously. No column is emitted after reset release until a new in_valid handshake.
- No X propagation: the buffer is reset, so col_data=0 when idle after reset.

Test Plan:
- FIPS-197 App. B round 1: in_state=d42711aee0bf98f1b8b45de51e415230, in_last=0, col_ready=1 → col_data d4bf5d30, e0b452ae, b84111f1, 1e2798e5 in 4 consecutive cycles. col_idx 0..3, col_eos only on the 4th, col_lastrnd=0. Feeding the column mixer, column 0 yields 046681e5.
- Back-to-back: two states offered with in_valid held 1, col_ready=1 → in_ready pulses in the col_idx==3 cycle. 8 columns in 8 consecutive cycles, no gap. Second state's in_last=1 is reflected on its 4 columns only.
- Backpressure: col_ready=0 for 3 cycles during column 1 → col_data stays e0b452ae with col_idx=1 throughout. in_ready=0. Sequence resumes correctly.
- Column-3 stall: col_ready=0 at col_idx==3 with in_valid=1 → in_ready=0 and the buffer is not overwritten. When col_ready rises, the handshakes on both channels occur in the same cycle.
- Identity/rotation check: in_state=000102030405060708090a0b0c0d0e0f → columns 00050a0f, 04090e03, 080d0207, 0c01060b.
- Reset mid-state: assert rst after column 1 accept → col_valid=0 and col_idx=0 immediately. After release, in_ready=1 and no stray columns appear; a new state emits from column 0.
